// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, FSM state encoding and the parity-check helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // The receiver uses this encoding now. The transmitter will reuse it later.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } uart_state_e;

  // Error flags carried alongside a received word.
  typedef struct packed {
    logic frame_err;
    logic parity_err;
  } uart_flags_t;

  // x is the XOR of the data bits and the received parity bit.
  function automatic logic parity_error(input logic x, input int mode);
    if (mode == PAR_ODD)  return ~x;
    if (mode == PAR_EVEN) return x;
    return 1'b0;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Received-word channel: data and flags with valid/ready, plus the overrun pulse and cts.
// Latency: n/a (wires only).
// Backpressure: the consumer holds ready low to keep the word. cts mirrors !valid.
// Ports: master = receiver (drives data/valid/flags/overrun/cts), slave = consumer (drives ready).
interface uart_rx_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;
  logic                 cts;

  modport master (output data, valid, frame_err, parity_err, overrun, cts, input ready);
  modport slave  (input data, valid, frame_err, parity_err, overrun, cts, output ready);
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running divider that emits a one-clock tick every CLK_DIV clocks.
// Latency: the first tick comes CLK_DIV-1 clocks after reset is released.
// Backpressure: none, because the divider never stalls.
// Ports: clk, rst (sync, active high), tick (high while the count equals CLK_DIV-1).
module uart_baud_tick #(
  parameter int CLK_DIV = 1300
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver. It validates the start bit, checks the optional parity bit and stop bits,
// and delivers each frame through a single-entry output register.
// Latency: valid rises on the clock after the tick of the last stop-bit sample.
// Backpressure: one unread word is held until ready. A frame that completes meanwhile is dropped and overrun pulses.
// Ports: clk, rst (sync, active high), rx (async serial in, idle high), busy (FSM not idle),
//        bus (master side of uart_rx_if: data/valid/ready/frame_err/parity_err/overrun/cts).
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = 1300,
  parameter int OVS       = 4,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       busy,
  uart_rx_if.master  bus
);
  localparam int PW = $clog2(OVS);
  localparam int BW = $clog2(DATA_BITS + 1);

  logic tick;

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Two-flop synchronizer. Both flops reset to the idle line level.
  logic rx_meta, rx_s;
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  uart_state_e          state, state_n;
  logic [PW-1:0]        phase, phase_n;
  logic [BW-1:0]        bitcnt, bitcnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  uart_flags_t          acc, acc_n;
  // Set after a frame whose last stop sample was low. Start detection stays off until the line
  // goes high again, so a held break yields a single frame.
  logic                 wait_high, wait_high_n;
  logic                 sample;
  logic                 commit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      phase     <= '0;
      bitcnt    <= '0;
      shreg     <= '0;
      acc       <= '0;
      wait_high <= 1'b0;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      bitcnt    <= bitcnt_n;
      shreg     <= shreg_n;
      acc       <= acc_n;
      wait_high <= wait_high_n;
    end
  end

  always_comb begin
    state_n     = state;
    phase_n     = phase;
    bitcnt_n    = bitcnt;
    shreg_n     = shreg;
    acc_n       = acc;
    wait_high_n = wait_high;
    commit      = 1'b0;
    sample      = tick && (phase == PW'(OVS - 1));

    if (rx_s) wait_high_n = 1'b0;

    // Outside IDLE and START, phase wraps at OVS-1 and each wrap is one bit's sample point.
    if (tick && (state == ST_DATA || state == ST_PAR || state == ST_STOP)) begin
      phase_n = sample ? '0 : phase + PW'(1);
    end

    case (state)
      ST_IDLE: begin
        if (tick && !rx_s && !wait_high) begin
          state_n = ST_START;
          phase_n = PW'(1);
        end
      end
      ST_START: begin
        if (tick) begin
          if (phase == PW'(OVS / 2)) begin
            if (rx_s) begin
              state_n = ST_IDLE;   // the line went high again, so this was a glitch and not a start bit
            end else begin
              state_n  = ST_DATA;
              phase_n  = '0;
              bitcnt_n = '0;
              acc_n    = '0;
            end
          end else begin
            phase_n = phase + PW'(1);
          end
        end
      end
      ST_DATA: begin
        if (sample) begin
          shreg_n  = {rx_s, shreg[DATA_BITS-1:1]};
          bitcnt_n = bitcnt + BW'(1);
          if (bitcnt == BW'(DATA_BITS - 1)) begin
            bitcnt_n = '0;
            state_n  = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
          end
        end
      end
      ST_PAR: begin
        if (sample) begin
          acc_n.parity_err = parity_error((^shreg) ^ rx_s, PARITY);
          state_n          = ST_STOP;
        end
      end
      ST_STOP: begin
        if (sample) begin
          acc_n.frame_err = acc.frame_err | ~rx_s;
          bitcnt_n        = bitcnt + BW'(1);
          if (bitcnt == BW'(STOP_BITS - 1)) begin
            commit      = 1'b1;
            state_n     = ST_IDLE;
            wait_high_n = ~rx_s;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Single-entry output register.
  logic [DATA_BITS-1:0] data_q;
  uart_flags_t          flags_q;
  logic                 valid_q;
  logic                 overrun_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      flags_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (commit) begin
        if (!valid_q || bus.ready) begin
          data_q  <= shreg;
          flags_q <= acc_n;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && bus.ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.data       = data_q;
  assign bus.valid      = valid_q;
  assign bus.frame_err  = flags_q.frame_err;
  assign bus.parity_err = flags_q.parity_err;
  assign bus.overrun    = overrun_q;
  assign bus.cts        = ~valid_q;
  assign busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx. CLK_DIV=4 and OVS=4 give 16 clocks per bit. It drives one unit
// without parity and one unit with even parity.
// Latency/backpressure: it checks word delivery, flags, glitch rejection, overrun and mid-frame reset.
module tb_uart_rx;
  logic clk;
  logic rst;
  logic rx0, rx2;
  logic busy0, busy2;

  uart_rx_if #(.DATA_BITS(8)) if0 ();
  uart_rx_if #(.DATA_BITS(8)) if2 ();

  uart_rx #(.CLK_DIV(4), .OVS(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_rx0 (
    .clk (clk), .rst (rst), .rx (rx0), .busy (busy0), .bus (if0)
  );
  uart_rx #(.CLK_DIV(4), .OVS(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_rx2 (
    .clk (clk), .rst (rst), .rx (rx2), .busy (busy2), .bus (if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Monitor: samples what the DUT sees at each active edge.
  int         acc0_cnt = 0, vh0_cnt = 0, ovr0_cnt = 0, busy0_cnt = 0, cts1_cnt = 0;
  logic [7:0] last0_data = '0;
  logic       last0_ferr = 1'b0, last0_perr = 1'b0;
  int         acc2_cnt = 0;
  logic [7:0] last2_data = '0;
  logic       last2_ferr = 1'b0, last2_perr = 1'b0;

  always @(posedge clk) begin
    if (if0.valid) vh0_cnt <= vh0_cnt + 1;
    if (if0.overrun) ovr0_cnt <= ovr0_cnt + 1;
    if (busy0) busy0_cnt <= busy0_cnt + 1;
    if (if0.cts) cts1_cnt <= cts1_cnt + 1;
    if (if0.valid && if0.ready) begin
      acc0_cnt   <= acc0_cnt + 1;
      last0_data <= if0.data;
      last0_ferr <= if0.frame_err;
      last0_perr <= if0.parity_err;
    end
    if (if2.valid && if2.ready) begin
      acc2_cnt   <= acc2_cnt + 1;
      last2_data <= if2.data;
      last2_ferr <= if2.frame_err;
      last2_perr <= if2.parity_err;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n falling edges, then settle 1 time unit so inputs never change on an edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic drive_bit(input int ln, input logic b);
    if (ln == 0) rx0 = b;
    else         rx2 = b;
    step(16);
  endtask

  task automatic idle(input int ln, input int nbits);
    repeat (nbits) drive_bit(ln, 1'b1);
  endtask

  task automatic send_frame(input int ln, input logic [7:0] d, input bit has_par,
                            input logic par, input logic stop);
    drive_bit(ln, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(ln, d[i]);
    if (has_par) drive_bit(ln, par);
    drive_bit(ln, stop);
  endtask

  int s_acc, s_vh, s_ovr, s_busy, s_cts;

  initial begin
    rst = 1'b1;
    rx0 = 1'b1;
    rx2 = 1'b1;
    if0.ready = 1'b1;
    if2.ready = 1'b1;
    step(4);

    // Reset state
    check("rst_valid",   {31'd0, if0.valid},      32'd0);
    check("rst_data",    {24'd0, if0.data},       32'd0);
    check("rst_ferr",    {31'd0, if0.frame_err},  32'd0);
    check("rst_perr",    {31'd0, if0.parity_err}, 32'd0);
    check("rst_overrun", {31'd0, if0.overrun},    32'd0);
    check("rst_busy",    {31'd0, busy0},          32'd0);
    check("rst_cts",     {31'd0, if0.cts},        32'd1);
    check("rst_valid2",  {31'd0, if2.valid},      32'd0);
    rst = 1'b0;
    step(20);

    // 0xA5, no parity, ready high
    s_acc = acc0_cnt; s_vh = vh0_cnt;
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    idle(0, 2);
    check("a5_count",  acc0_cnt - s_acc,     32'd1);
    check("a5_vhigh",  vh0_cnt - s_vh,       32'd1);
    check("a5_data",   {24'd0, last0_data},  32'hA5);
    check("a5_ferr",   {31'd0, last0_ferr},  32'd0);
    check("a5_perr",   {31'd0, last0_perr},  32'd0);
    check("a5_idle",   {31'd0, busy0},       32'd0);

    // Even parity: 0x07 has three ones, so parity bit 0 is wrong and 1 is right
    s_acc = acc2_cnt;
    send_frame(2, 8'h07, 1'b1, 1'b0, 1'b1);
    idle(2, 2);
    check("par_bad_count", acc2_cnt - s_acc,    32'd1);
    check("par_bad_data",  {24'd0, last2_data}, 32'h07);
    check("par_bad_perr",  {31'd0, last2_perr}, 32'd1);
    check("par_bad_ferr",  {31'd0, last2_ferr}, 32'd0);
    send_frame(2, 8'h07, 1'b1, 1'b1, 1'b1);
    idle(2, 2);
    check("par_ok_count",  acc2_cnt - s_acc,    32'd2);
    check("par_ok_perr",   {31'd0, last2_perr}, 32'd0);

    // Stop bit low: the data is still delivered, with frame_err set
    s_acc = acc0_cnt;
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b0);
    idle(0, 2);
    check("ferr_count", acc0_cnt - s_acc,    32'd1);
    check("ferr_data",  {24'd0, last0_data}, 32'h5A);
    check("ferr_flag",  {31'd0, last0_ferr}, 32'd1);

    // A 20-bit break gives exactly one all-zero frame with frame_err set
    s_acc = acc0_cnt;
    rx0 = 1'b0;
    step(20 * 16);
    idle(0, 3);
    check("brk_count", acc0_cnt - s_acc,    32'd1);
    check("brk_data",  {24'd0, last0_data}, 32'h00);
    check("brk_ferr",  {31'd0, last0_ferr}, 32'd1);

    // A low glitch of one tick: START holds for two ticks, the state returns to IDLE, and no word appears
    s_acc = acc0_cnt; s_vh = vh0_cnt; s_busy = busy0_cnt;
    rx0 = 1'b0;
    step(4);
    rx0 = 1'b1;
    step(60);
    check("glitch_busy",  busy0_cnt - s_busy, 32'd8);
    check("glitch_valid", vh0_cnt - s_vh,     32'd0);
    check("glitch_count", acc0_cnt - s_acc,   32'd0);
    check("glitch_idle",  {31'd0, busy0},     32'd0);

    // Overrun: ready low, 0x11 then 0x22 back to back
    if0.ready = 1'b0;
    s_ovr = ovr0_cnt; s_acc = acc0_cnt;
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
    s_cts = cts1_cnt;
    send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
    idle(0, 2);
    check("ovr_valid",   {31'd0, if0.valid}, 32'd1);
    check("ovr_data",    {24'd0, if0.data},  32'h11);
    check("ovr_pulses",  ovr0_cnt - s_ovr,   32'd1);
    check("ovr_cts_low", cts1_cnt - s_cts,   32'd0);
    if0.ready = 1'b1;
    step(2);
    check("ovr_drain_valid", {31'd0, if0.valid},  32'd0);
    check("ovr_drain_cts",   {31'd0, if0.cts},    32'd1);
    check("ovr_drain_count", acc0_cnt - s_acc,    32'd1);
    check("ovr_drain_data",  {24'd0, last0_data}, 32'h11);

    // Reset during the 4th data bit, with an unread flagged word pending
    if0.ready = 1'b0;
    send_frame(0, 8'h99, 1'b0, 1'b0, 1'b0);
    idle(0, 1);
    check("pre_rst_valid", {31'd0, if0.valid},     32'd1);
    check("pre_rst_ferr",  {31'd0, if0.frame_err}, 32'd1);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    rx0 = 1'b1;
    step(8);
    check("pre_rst_busy", {31'd0, busy0}, 32'd1);
    rst = 1'b1;
    step(1);
    check("mid_rst_valid",   {31'd0, if0.valid},      32'd0);
    check("mid_rst_data",    {24'd0, if0.data},       32'd0);
    check("mid_rst_ferr",    {31'd0, if0.frame_err},  32'd0);
    check("mid_rst_perr",    {31'd0, if0.parity_err}, 32'd0);
    check("mid_rst_overrun", {31'd0, if0.overrun},    32'd0);
    check("mid_rst_busy",    {31'd0, busy0},          32'd0);
    check("mid_rst_cts",     {31'd0, if0.cts},        32'd1);
    step(1);
    rst = 1'b0;
    if0.ready = 1'b1;
    idle(0, 2);
    s_acc = acc0_cnt;
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    idle(0, 2);
    check("post_rst_count", acc0_cnt - s_acc,    32'd1);
    check("post_rst_data",  {24'd0, last0_data}, 32'h3C);
    check("post_rst_ferr",  {31'd0, last0_ferr}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

Parametrised, oversampling UART receiver with start-bit validation, optional parity, 1 or 2 stop bits, and per-frame error flags. Serial data arrives on `rx` and is delivered as one word per frame through a single-entry valid/ready output register. `cts` advertises when that register is free. The block sits between the board-level serial pin and the byte-consuming logic, typically the SPI bridge.

## Interface
Parameters:
- `CLK_DIV`, default 1300: clocks per oversample tick (50 MHz, 9600 baud, ×4).
- `OVS`, default 4: ticks per bit. Must be even and ≥4.
- `DATA_BITS`, default 8: data bits per frame, 5–9.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: 1 or 2.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial input, idle high.
- `data`  out  DATA_BITS  received word, LSB = first bit on the wire.
- `valid`  out  1  `data`/flags hold an unread frame.
- `ready`  in  1  consumer accepts the frame on a cycle where `valid && ready`.
- `frame_err`  out  1  stop bit(s) sampled low; qualified by `valid`.
- `parity_err`  out  1  parity mismatch; qualified by `valid`; always 0 when PARITY=0.
- `overrun`  out  1  one-cycle pulse: a completed frame was dropped because `valid` was still high.
- `cts`  out  1  equals `!valid`.
- `busy`  out  1  FSM not in IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer to produce `rx_s`. Both flops reset to 1.
- The tick generator counts 0..CLK_DIV-1 and pulses `tick` for one clock at CLK_DIV-1. It runs freely and is cleared by `rst`.
- `phase` counts ticks within a bit. It is 0..OVS-1 and is only meaningful outside IDLE.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: on a tick with `rx_s==0`, go to START with `phase=1`.
  - START: on a tick with `phase==OVS/2`, check `rx_s`.
    - If `rx_s==1`, this is a false start; return to IDLE.
    - Otherwise set `phase=0`, `bitcnt=0`, and go to DATA.
    - On other ticks, `phase++`.
  - DATA, PAR, STOP: a sample point is a tick with `phase==OVS-1`; on it, set `phase=0`. On other ticks, `phase++`.
  - DATA: at each sample point, shift `rx_s` into the shift register (LSB first) and increment `bitcnt`. After DATA_BITS samples, go to PAR if PARITY≠0, else STOP.
  - PAR: sample one bit, compute the error, then go to STOP.
    - Odd parity: error if XOR(data, parity bit) == 0.
    - Even parity: error if XOR(data, parity bit) == 1.
  - STOP: sample STOP_BITS bits. `frame_err` is the OR of (sample==0) across those bits. After the last stop sample, commit the frame and go to IDLE on the same clock. This allows a new start edge to be detected during the second half of the stop bit.
- Commit rules:
  - If `valid==0`, or `valid && ready` on the commit clock, load `data` and both flags, and set `valid=1`.
  - If `valid && !ready`, drop the new frame, keep the old frame intact, and pulse `overrun`.
- Frames with `frame_err` or `parity_err` set are still delivered.
- `valid` clears on the clock after `valid && ready`, unless a commit occurs on that same clock.
- `data` and the flags are stable while `valid` is high.
- A break condition (`rx` held low) produces one frame of all zeros with `frame_err=1`. No further frame follows until `rx` returns high and then falls again.

## Timing
- Reset values: `valid=0`, `data=0`, `frame_err=0`, `parity_err=0`, `overrun=0`, `busy=0`, `cts=1`, FSM=IDLE, tick counter=0.
- `rst` asserted mid-frame discards the partial frame and any unread frame on the next clock.
- Bit period = CLK_DIV·OVS clocks. The start edge is detected 2 clocks (synchronizer) plus up to one tick period late.
- `valid` rises on the clock after the tick of the last stop-bit sample.
- `overrun` rises on that same clock, for one cycle.
- Reception tolerates ±(OVS/2−1)/OVS of a bit of cumulative drift at the final sample.

## Structure
- Package `uart_pkg` holds:
  - parity constants `PAR_NONE=0`, `PAR_ODD=1`, `PAR_EVEN=2`;
  - the FSM state encoding, shared with the future `uart_tx`.
- Sub-module `uart_baud_tick`, parameter CLK_DIV: free-running divider with ports `clk`, `rst`, `tick`. It is reused by `uart_tx`.

## Test plan
All scenarios use CLK_DIV=4 and OVS=4, so one bit = 16 clocks.
- Frame 0xA5, PARITY=0, 1 stop bit, `ready` held high → `data=0xA5`, `valid` high for 1 cycle, no flags set.
- PARITY=2, frame 0x07 sent with parity bit 0 → `parity_err=1`. Resend with parity bit 1 → `parity_err=0`.
- Stop bit driven 0 → `frame_err=1` with data delivered. 20-bit low break → exactly one frame, 0x00, with `frame_err=1`.
- 1-tick low glitch on `rx` → `busy` pulses, returns to IDLE, and no `valid`.
- `ready=0`: send 0x11 then 0x22 back-to-back → `data` stays 0x11, `overrun` pulses once, `cts=0` throughout. Asserting `ready` then gives `valid=0` and `cts=1`.
- Assert `rst` during the 4th data bit → all outputs return to reset values. The next clean frame 0x3C is received correctly.
